// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Brief    : Shared defines for the pipeline hazard/flush controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int StallSignalLen = 6;

    localparam int StallPc    = 0;
    localparam int StallIfId  = 1;
    localparam int StallIdEx  = 2;
    localparam int StallExMem = 3;
    localparam int StallMemWb = 4;

    localparam logic [StallSignalLen-1:0] Zero = '0;

    localparam int ArbStateW = 2;
    typedef logic [ArbStateW-1:0] arb_state_t;

    localparam arb_state_t c_ARB_IDLE     = 2'd0;
    localparam arb_state_t c_ARB_IF_BUSY  = 2'd1;
    localparam arb_state_t c_ARB_MEM_BUSY = 2'd2;

    // Hold every pipeline register from the PC up to and including stage idx.
    function automatic logic [StallSignalLen-1:0] stall_upto(input int idx);
        return StallSignalLen'((32'd1 << (idx + 1)) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_arb
// Brief    : Memory-port arbiter between IF and MEM with stale-fetch discard.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl_arb
    import pipeline_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_mem_req,
    input  logic i_mem_done,
    input  logic i_jump_flag,
    output logic o_mem_start,
    output logic o_mem_sel,
    output logic o_if_ack,
    output logic o_mem_ack
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_stale;
    logic       r_mem_start;
    logic       r_mem_sel;
    logic       r_if_ack;
    logic       r_mem_ack;
    logic       w_stale_nxt;
    logic       w_mem_start_nxt;
    logic       w_mem_sel_nxt;
    logic       w_if_ack_nxt;
    logic       w_mem_ack_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ARB_IDLE;
            r_stale     <= 1'b0;
            r_mem_start <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stale     <= w_stale_nxt;
            r_mem_start <= w_mem_start_nxt;
            r_mem_sel   <= w_mem_sel_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_mem_ack   <= w_mem_ack_nxt;
        end
    end

    // An ack cycle still sees the requester's old request; skip it to avoid a double grant.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ARB_IDLE: begin
                if (!(r_if_ack || r_mem_ack)) begin
                    if (i_mem_req)
                        w_state_nxt = c_ARB_MEM_BUSY;
                    else if (i_if_req)
                        w_state_nxt = c_ARB_IF_BUSY;
                end
            end
            c_ARB_IF_BUSY,
            c_ARB_MEM_BUSY: begin
                if (i_mem_done)
                    w_state_nxt = c_ARB_IDLE;
            end
            default: w_state_nxt = c_ARB_IDLE;
        endcase
    end

    // A jump in the completion cycle also makes the fetch wrong-path.
    always_comb begin
        w_mem_start_nxt = (r_state == c_ARB_IDLE) && (w_state_nxt != c_ARB_IDLE);
        w_mem_sel_nxt   = r_mem_sel;
        if (w_mem_start_nxt)
            w_mem_sel_nxt = (w_state_nxt == c_ARB_MEM_BUSY);
        w_if_ack_nxt  = (r_state == c_ARB_IF_BUSY) && i_mem_done && !(r_stale || i_jump_flag);
        w_mem_ack_nxt = (r_state == c_ARB_MEM_BUSY) && i_mem_done;
        w_stale_nxt   = r_stale;
        if (r_state == c_ARB_IF_BUSY) begin
            if (i_mem_done)
                w_stale_nxt = 1'b0;
            else if (i_jump_flag)
                w_stale_nxt = 1'b1;
        end
    end

    assign o_mem_start = r_mem_start;
    assign o_mem_sel   = r_mem_sel;
    assign o_if_ack    = r_if_ack;
    assign o_mem_ack   = r_mem_ack;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Hazard/flush controller and memory-port arbiter for the 5-stage
//            core. Define PIPELINE_CTRL_PERF_EN to build the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STALL_W = StallSignalLen
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic               mem_req,
    input  logic               id_stall_req,
    input  logic               ex_jump_req,
    input  logic               mem_done,
    output logic               mem_start,
    output logic               mem_sel,
    output logic               if_ack,
    output logic               mem_ack,
    output logic               if_bubble,
    output logic               id_bubble,
    output logic [STALL_W-1:0] stall_signal,
    output logic               jump_flag,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flushes
);

    pipeline_ctrl_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_if_req    (if_req),
        .i_mem_req   (mem_req),
        .i_mem_done  (mem_done),
        .i_jump_flag (jump_flag),
        .o_mem_start (mem_start),
        .o_mem_sel   (mem_sel),
        .o_if_ack    (if_ack),
        .o_mem_ack   (mem_ack)
    );

    // A jump waiting behind a MEM access is deferred: EX is held, so the request persists.
    always_comb begin
        stall_signal = STALL_W'(Zero);
        jump_flag    = 1'b0;
        if_bubble    = 1'b0;
        id_bubble    = 1'b0;
        if (mem_req && !mem_ack) begin
            stall_signal = STALL_W'(stall_upto(StallMemWb));
        end else if (ex_jump_req) begin
            jump_flag = 1'b1;
        end else if (id_stall_req) begin
            stall_signal = STALL_W'(stall_upto(StallIfId));
            id_bubble    = 1'b1;
        end else if (if_req && !if_ack) begin
            stall_signal = STALL_W'(stall_upto(StallPc));
            if_bubble    = 1'b1;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_flushes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cycles <= 32'd0;
            r_perf_flushes      <= 32'd0;
        end else begin
            if (|stall_signal)
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            if (jump_flag)
                r_perf_flushes <= r_perf_flushes + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_flushes      = r_perf_flushes;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flushes      = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Randomized scoreboard bench for pipeline_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic        mem_req = 1'b0;
    logic        id_stall_req = 1'b0;
    logic        ex_jump_req = 1'b0;
    logic        mem_done = 1'b0;
    logic        mem_start;
    logic        mem_sel;
    logic        if_ack;
    logic        mem_ack;
    logic        if_bubble;
    logic        id_bubble;
    logic [5:0]  stall_signal;
    logic        jump_flag;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;

    always #5 clk = ~clk;

    pipeline_ctrl #(.STALL_W(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_req            (if_req),
        .mem_req           (mem_req),
        .id_stall_req      (id_stall_req),
        .ex_jump_req       (ex_jump_req),
        .mem_done          (mem_done),
        .mem_start         (mem_start),
        .mem_sel           (mem_sel),
        .if_ack            (if_ack),
        .mem_ack           (mem_ack),
        .if_bubble         (if_bubble),
        .id_bubble         (id_bubble),
        .stall_signal      (stall_signal),
        .jump_flag         (jump_flag),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { int cyc; int sel;  } start_t;
    typedef struct { int cyc; int kind; } ack_t;   // kind 1 = IF, 2 = MEM
    start_t q_start[$];
    ack_t   q_ack[$];

    // Reference model: who owns the port, whether the fetch went stale, and
    // what the registered handshakes must look like in the current cycle.
    int          m_owner = 0;                      // 0 none, 1 IF, 2 MEM
    bit          m_stale = 0;
    bit          e_start = 0, e_sel = 0, e_if_ack = 0, e_mem_ack = 0;
    bit          last_if_ack = 0, last_mem_ack = 0, last_jump = 0;
    bit          ejump, eib, eidb;
    logic [5:0]  estall;
    int          done_at = -1;
    int          quiet_until = -1;
    bit          rst_done = 0;
    logic [31:0] m_perf_stall = 0, m_perf_fl = 0;

    localparam int NCYC  = 2500;
    localparam int DRAIN = 30;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a handshake.
    always @(negedge clk) begin
        start_t s;
        ack_t   a;
        if (mem_start === 1'b1) begin
            if (q_start.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_mem_start cyc=%0d actual=1 expected=0", cyc);
            end else begin
                s = q_start.pop_front();
                check("mem_start_cycle", cyc, s.cyc);
                check("mem_sel", {31'd0, mem_sel}, s.sel);
            end
        end
        if (if_ack === 1'b1 || mem_ack === 1'b1) begin
            if (q_ack.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack cyc=%0d actual_if=%0b actual_mem=%0b expected=none",
                         cyc, if_ack, mem_ack);
            end else begin
                a = q_ack.pop_front();
                check("ack_cycle", cyc, a.cyc);
                check("ack_kind", (if_ack === 1'b1 && mem_ack === 1'b1) ? 3 : (if_ack ? 1 : 2), a.kind);
            end
        end
    end

    task automatic drive(input int n);
        bit quiet;
        quiet = (cyc <= quiet_until) || (n >= NCYC - DRAIN);
        rst   = (n < 3);
        if (!rst_done && n > 800 && m_owner == 2 && cyc < done_at) begin
            rst         = 1'b1;
            rst_done    = 1;
            quiet_until = done_at + 2;
            quiet       = 1;
        end
        if (rst) begin
            if_req = 0; mem_req = 0; ex_jump_req = 0; id_stall_req = 0;
        end else begin
            if (!(if_req && !last_if_ack))
                if_req = !quiet && ($urandom_range(0, 2) == 0);
            if (!(mem_req && !last_mem_ack))
                mem_req = !quiet && ($urandom_range(0, 4) == 0);
            if (!(ex_jump_req && !last_jump))
                ex_jump_req = !quiet && ($urandom_range(0, 9) == 0);
            id_stall_req = !quiet && ($urandom_range(0, 5) == 0);
        end
        mem_done = (cyc == done_at) || (m_owner == 0 && $urandom_range(0, 9) == 0);
    endtask

    task automatic check_comb();
        estall = 6'b000000; ejump = 0; eib = 0; eidb = 0;
        if (mem_req && !e_mem_ack)        estall = 6'b011111;
        else if (ex_jump_req)             ejump  = 1;
        else if (id_stall_req)            begin estall = 6'b000011; eidb = 1; end
        else if (if_req && !e_if_ack)     begin estall = 6'b000001; eib = 1; end
        check("stall_signal", {26'd0, stall_signal}, {26'd0, estall});
        check("jump_flag", {31'd0, jump_flag}, {31'd0, ejump});
        check("if_bubble", {31'd0, if_bubble}, {31'd0, eib});
        check("id_bubble", {31'd0, id_bubble}, {31'd0, eidb});
    endtask

    task automatic model_update();
        bit n_start, n_if, n_mem;
        n_start = 0; n_if = 0; n_mem = 0;
        last_if_ack  = e_if_ack;
        last_mem_ack = e_mem_ack;
        last_jump    = ejump;
        if (rst) begin
            m_perf_stall = 0; m_perf_fl = 0;
            m_owner = 0; m_stale = 0; e_sel = 0;
        end else begin
            if (estall != 0) m_perf_stall++;
            if (ejump)       m_perf_fl++;
            if (m_owner == 0) begin
                if (!e_if_ack && !e_mem_ack) begin
                    if (mem_req)     begin m_owner = 2; e_sel = 1; n_start = 1; end
                    else if (if_req) begin m_owner = 1; e_sel = 0; n_start = 1; end
                end
            end else if (mem_done) begin
                n_if  = (m_owner == 1) && !(m_stale || ejump);
                n_mem = (m_owner == 2);
                m_owner = 0; m_stale = 0;
            end else if (m_owner == 1 && ejump) begin
                m_stale = 1;
            end
        end
        e_start = n_start; e_if_ack = n_if; e_mem_ack = n_mem;
        if (n_start) begin
            q_start.push_back('{cyc + 1, int'(e_sel)});
            done_at = cyc + 1 + int'($urandom_range(0, 3));
        end
        if (n_if)  q_ack.push_back('{cyc + 1, 1});
        if (n_mem) q_ack.push_back('{cyc + 1, 2});
    endtask

    initial begin
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            cyc++;
            #1;
            drive(n);
            @(negedge clk);
            if (n == 3) begin
                check("reset_mem_start", {31'd0, mem_start}, 32'd0);
                check("reset_mem_sel", {31'd0, mem_sel}, 32'd0);
                check("reset_if_ack", {31'd0, if_ack}, 32'd0);
                check("reset_mem_ack", {31'd0, mem_ack}, 32'd0);
                check("reset_perf_stall", perf_stall_cycles, 32'd0);
                check("reset_perf_flush", perf_flushes, 32'd0);
            end
            check_comb();
            model_update();
        end
        @(posedge clk);
        cyc++;
        #1;
`ifdef PIPELINE_CTRL_PERF_EN
        check("perf_stall_cycles", perf_stall_cycles, m_perf_stall);
        check("perf_flushes", perf_flushes, m_perf_fl);
`else
        check("perf_stall_cycles", perf_stall_cycles, 32'd0);
        check("perf_flushes", perf_flushes, 32'd0);
`endif
        check("start_queue_drained", q_start.size(), 32'd0);
        check("ack_queue_drained", q_ack.size(), 32'd0);
        check("mid_run_reset_hit", {31'd0, rst_done}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
